// File: rtl/multdiv_scoreboard_pkg.sv
// Shared opcode constants, exception codes and state encoding for the
// multdiv scoreboard and its instruction decoder.
package multdiv_scoreboard_pkg;

  localparam logic [4:0] OP_ALU  = 5'd0;
  localparam logic [4:0] OP_J    = 5'd1;
  localparam logic [4:0] OP_BNE  = 5'd2;
  localparam logic [4:0] OP_JAL  = 5'd3;
  localparam logic [4:0] OP_JR   = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_BLT  = 5'd6;
  localparam logic [4:0] OP_SW   = 5'd7;
  localparam logic [4:0] OP_LW   = 5'd8;
  localparam logic [4:0] OP_SETX = 5'd21;
  localparam logic [4:0] OP_BEX  = 5'd22;

  localparam logic [4:0] MULT_ALUOP = 5'b00110;
  localparam logic [4:0] DIV_ALUOP  = 5'b00111;

  localparam logic [4:0]  STATUS_REG    = 5'd30;
  localparam logic [4:0]  LINK_REG      = 5'd31;
  localparam logic [31:0] MULT_EXC_CODE = 32'd4;
  localparam logic [31:0] DIV_EXC_CODE  = 32'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } md_state_e;

  function automatic logic is_md_instr(input logic [31:0] ir);
    return (ir[31:27] == OP_ALU) &&
           ((ir[6:2] == MULT_ALUOP) || (ir[6:2] == DIV_ALUOP));
  endfunction

endpackage

// File: rtl/multdiv_scoreboard_md_instr_decode.sv
// Combinational decode of one instruction word: multdiv flag, the registers
// it reads (0 when a slot is unused) and the register it writes.
module md_instr_decode
  import multdiv_scoreboard_pkg::*;
(
  input  logic [31:0] ir,
  output logic        is_md,
  output logic [4:0]  src_a,
  output logic [4:0]  src_b,
  output logic [4:0]  dest,
  output logic        writes
);

  logic [4:0] op_s;
  logic [4:0] rd_s;
  logic [4:0] rs_s;
  logic [4:0] rt_s;
  logic       unused_bits;

  assign op_s        = ir[31:27];
  assign rd_s        = ir[26:22];
  assign rs_s        = ir[21:17];
  assign rt_s        = ir[16:12];
  assign is_md       = is_md_instr(ir);
  assign unused_bits = ^{ir[11:7], ir[1:0]};

  always_comb begin
    src_a  = 5'd0;
    src_b  = 5'd0;
    dest   = 5'd0;
    writes = 1'b0;
    case (op_s)
      OP_ALU: begin
        src_a  = rs_s;
        src_b  = rt_s;
        writes = !is_md;
        dest   = is_md ? 5'd0 : rd_s;
      end
      OP_SW: begin
        src_a = rs_s;
        src_b = rd_s;
      end
      OP_LW: begin
        src_a  = rs_s;
        src_b  = rd_s;
        writes = 1'b1;
        dest   = rd_s;
      end
      OP_BNE, OP_BLT: begin
        src_a = rd_s;
        src_b = rs_s;
      end
      OP_JR: begin
        src_a = rd_s;
      end
      OP_BEX: begin
        src_a = STATUS_REG;
      end
      OP_ADDI: begin
        src_a  = rs_s;
        writes = 1'b1;
        dest   = rd_s;
      end
      OP_JAL: begin
        src_a  = rs_s;
        writes = 1'b1;
        dest   = LINK_REG;
      end
      OP_SETX: begin
        src_a  = rs_s;
        writes = 1'b1;
        dest   = STATUS_REG;
      end
      default: begin
        src_a = rs_s;
      end
    endcase
  end

endmodule

// File: rtl/multdiv_scoreboard.sv
// Sequences the iterative multiply/divide unit: issues start pulses, stalls
// decode on hazards against the in-flight result and arbitrates the write port.
module multdiv_scoreboard
  import multdiv_scoreboard_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] FDIR,
  input  logic [31:0] DXIR,
  input  logic [31:0] MWIR,
  input  logic        multdiv_ready,
  input  logic        multdiv_exception,
  input  logic [31:0] multdiv_result,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        stall,
  output logic        md_busy,
  output logic        md_wb_grant,
  output logic [4:0]  md_wb_rd,
  output logic [31:0] md_wb_data
);

  md_state_e   state_q, state_d;
  logic [4:0]  pend_rd_q, pend_rd_d;
  logic        pend_is_div_q, pend_is_div_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic [4:0]  hold_rd_q, hold_rd_d;

  logic        fd_is_md, fd_writes;
  logic [4:0]  fd_src_a, fd_src_b, fd_dest;
  logic        mw_is_md, mw_writes;
  logic [4:0]  mw_src_a, mw_src_b, mw_dest;

  logic        dx_is_md, dx_is_div;
  logic [4:0]  dx_rd;
  logic [31:0] res_data_s;
  logic [4:0]  res_rd_s;
  logic        start_s, grant_s;
  logic [4:0]  wb_rd_s;
  logic [31:0] wb_data_s;
  logic [4:0]  pend_s;
  logic        active_s, hazard_s;
  logic        unused_sink;

  md_instr_decode u_fd_dec (
    .ir(FDIR), .is_md(fd_is_md), .src_a(fd_src_a), .src_b(fd_src_b),
    .dest(fd_dest), .writes(fd_writes)
  );

  md_instr_decode u_mw_dec (
    .ir(MWIR), .is_md(mw_is_md), .src_a(mw_src_a), .src_b(mw_src_b),
    .dest(mw_dest), .writes(mw_writes)
  );

  assign dx_is_md    = is_md_instr(DXIR);
  assign dx_is_div   = (DXIR[6:2] == DIV_ALUOP);
  assign dx_rd       = DXIR[26:22];
  assign unused_sink = ^{DXIR[21:7], DXIR[1:0], mw_is_md, mw_src_a, mw_src_b, mw_dest};

  // Result routing: an exception redirects a fixed code to the status register.
  always_comb begin
    if (multdiv_exception) begin
      res_data_s = pend_is_div_q ? DIV_EXC_CODE : MULT_EXC_CODE;
      res_rd_s   = STATUS_REG;
    end else begin
      res_data_s = multdiv_result;
      res_rd_s   = pend_rd_q;
    end
  end

  // Next-state, start pulse and write-port arbitration (MW always wins).
  always_comb begin
    state_d       = state_q;
    pend_rd_d     = pend_rd_q;
    pend_is_div_d = pend_is_div_q;
    hold_data_d   = hold_data_q;
    hold_rd_d     = hold_rd_q;
    start_s       = 1'b0;
    grant_s       = 1'b0;
    wb_rd_s       = 5'd0;
    wb_data_s     = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (dx_is_md) begin
          start_s       = 1'b1;
          pend_rd_d     = dx_rd;
          pend_is_div_d = dx_is_div;
          state_d       = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (multdiv_ready && !mw_writes) begin
          grant_s   = (res_rd_s != 5'd0);
          wb_rd_s   = res_rd_s;
          wb_data_s = res_data_s;
          state_d   = ST_IDLE;
        end else if (multdiv_ready) begin
          hold_data_d = res_data_s;
          hold_rd_d   = res_rd_s;
          state_d     = ST_HOLD;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_HOLD: begin
        if (!mw_writes) begin
          grant_s   = (hold_rd_q != 5'd0);
          wb_rd_s   = hold_rd_q;
          wb_data_s = hold_data_q;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Hazard detection against whichever destination is currently in flight.
  always_comb begin
    if (state_q == ST_IDLE && dx_is_md) begin
      pend_s = dx_rd;
    end else if (state_q == ST_HOLD) begin
      pend_s = hold_rd_q;
    end else begin
      pend_s = pend_rd_q;
    end
    active_s = (state_q != ST_IDLE) || dx_is_md;
    hazard_s = fd_is_md ||
               ((pend_s != 5'd0) && ((fd_src_a == pend_s) || (fd_src_b == pend_s) ||
                                     (fd_writes && (fd_dest == pend_s)))) ||
               (FDIR[31:27] == OP_BEX);
  end

  // Combinational outputs are forced low while reset is held.
  assign ctrl_MULT   = reset & start_s & !dx_is_div;
  assign ctrl_DIV    = reset & start_s & dx_is_div;
  assign stall       = reset & active_s & hazard_s;
  assign md_busy     = reset & (state_q != ST_IDLE);
  assign md_wb_grant = reset & grant_s;
  assign md_wb_rd    = (reset && grant_s) ? wb_rd_s : 5'd0;
  assign md_wb_data  = (reset && grant_s) ? wb_data_s : 32'd0;

  // Scoreboard state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      pend_rd_q     <= 5'd0;
      pend_is_div_q <= 1'b0;
      hold_data_q   <= 32'd0;
      hold_rd_q     <= 5'd0;
    end else begin
      state_q       <= state_d;
      pend_rd_q     <= pend_rd_d;
      pend_is_div_q <= pend_is_div_d;
      hold_data_q   <= hold_data_d;
      hold_rd_q     <= hold_rd_d;
    end
  end

endmodule

// File: tb/tb_multdiv_scoreboard.sv
// Directed bench for multdiv_scoreboard: start pulses, grant/hold arbitration,
// exceptions, decode hazards, r0 destinations and mid-operation reset.
module tb_multdiv_scoreboard;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] FDIR = 32'd0, DXIR = 32'd0, MWIR = 32'd0;
  logic        multdiv_ready = 1'b0, multdiv_exception = 1'b0;
  logic [31:0] multdiv_result = 32'd0;
  logic        ctrl_MULT, ctrl_DIV, stall, md_busy, md_wb_grant;
  logic [4:0]  md_wb_rd;
  logic [31:0] md_wb_data;

  int total = 0;
  int bad   = 0;

  // sw r0,0(r0): an MW instruction that does not use the write port
  localparam logic [31:0] MW_FREE = 32'h3800_0000;

  multdiv_scoreboard dut (
    .clock(clock), .reset(reset), .FDIR(FDIR), .DXIR(DXIR), .MWIR(MWIR),
    .multdiv_ready(multdiv_ready), .multdiv_exception(multdiv_exception),
    .multdiv_result(multdiv_result), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .stall(stall), .md_busy(md_busy), .md_wb_grant(md_wb_grant),
    .md_wb_rd(md_wb_rd), .md_wb_data(md_wb_data)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] r_ins(input logic [4:0] alu, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {5'd0, rd, rs, rt, 5'd0, alu, 2'b00};
  endfunction

  function automatic logic [31:0] i_ins(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs);
    return {op, rd, rs, 17'd0};
  endfunction

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    FDIR = 32'd0; DXIR = 32'd0; MWIR = MW_FREE;
    multdiv_ready = 1'b0; multdiv_exception = 1'b0; multdiv_result = 32'd0;
  endtask

  task automatic test_reset();
    DXIR = r_ins(5'd6, 5'd3, 5'd1, 5'd2);
    FDIR = r_ins(5'd6, 5'd4, 5'd3, 5'd1);
    multdiv_ready = 1'b1;
    #2;
    total++;
    if ({ctrl_MULT, ctrl_DIV, stall, md_busy, md_wb_grant, md_wb_rd, md_wb_data} !== 42'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b%b%b%b%b rd=%0d data=%h exp=all zero",
               ctrl_MULT, ctrl_DIV, stall, md_busy, md_wb_grant, md_wb_rd, md_wb_data);
    end
    cycle();
    quiet();
    cycle();
    reset = 1'b1;
    cycle();
  endtask

  task automatic test_mul_grant();
    DXIR = r_ins(5'd6, 5'd3, 5'd1, 5'd2);
    #2;
    total++;
    if (ctrl_MULT !== 1'b1 || ctrl_DIV !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL mul_start got mult=%b div=%b stall=%b exp 1 0 0", ctrl_MULT, ctrl_DIV, stall);
    end
    cycle();
    DXIR = 32'd0;
    #2;
    total++;
    if (ctrl_MULT !== 1'b0 || md_busy !== 1'b1) begin
      bad++;
      $display("FAIL mul_one_pulse got mult=%b busy=%b exp 0 1", ctrl_MULT, md_busy);
    end
    repeat (15) cycle();
    cycle();
    multdiv_ready = 1'b1; multdiv_result = 32'h1234_5678;
    FDIR = r_ins(5'd0, 5'd4, 5'd3, 5'd1);
    #2;
    total++;
    if (md_wb_grant !== 1'b1 || md_wb_rd !== 5'd3 || md_wb_data !== 32'h1234_5678 || stall !== 1'b1) begin
      bad++;
      $display("FAIL mul_grant got g=%b rd=%0d data=%h stall=%b exp 1 3 12345678 1",
               md_wb_grant, md_wb_rd, md_wb_data, stall);
    end
    cycle();
    multdiv_ready = 1'b0;
    #2;
    total++;
    if (md_busy !== 1'b0 || md_wb_grant !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL mul_after_grant got busy=%b g=%b stall=%b exp 0 0 0", md_busy, md_wb_grant, stall);
    end
    quiet();
  endtask

  task automatic test_hold();
    cycle();
    DXIR = r_ins(5'd6, 5'd3, 5'd1, 5'd2);
    cycle();
    DXIR = 32'd0;
    multdiv_ready = 1'b1; multdiv_result = 32'hCAFE_0001;
    MWIR = i_ins(5'd5, 5'd5, 5'd1);
    #2;
    total++;
    if (md_wb_grant !== 1'b0 || md_busy !== 1'b1) begin
      bad++;
      $display("FAIL hold_blocked got g=%b busy=%b exp 0 1", md_wb_grant, md_busy);
    end
    cycle();
    multdiv_ready = 1'b0; multdiv_result = 32'h0BAD_0BAD;
    FDIR = r_ins(5'd0, 5'd4, 5'd3, 5'd1);
    #2;
    total++;
    if (md_wb_grant !== 1'b0 || stall !== 1'b1) begin
      bad++;
      $display("FAIL hold_wait got g=%b stall=%b exp 0 1", md_wb_grant, stall);
    end
    cycle();
    MWIR = MW_FREE;
    #2;
    total++;
    if (md_wb_grant !== 1'b1 || md_wb_rd !== 5'd3 || md_wb_data !== 32'hCAFE_0001) begin
      bad++;
      $display("FAIL hold_grant got g=%b rd=%0d data=%h exp 1 3 cafe0001",
               md_wb_grant, md_wb_rd, md_wb_data);
    end
    cycle();
    #2;
    total++;
    if (md_busy !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL hold_idle got busy=%b stall=%b exp 0 0", md_busy, stall);
    end
    quiet();
  endtask

  task automatic test_exception();
    cycle();
    DXIR = r_ins(5'd7, 5'd7, 5'd1, 5'd2);
    #2;
    total++;
    if (ctrl_DIV !== 1'b1 || ctrl_MULT !== 1'b0) begin
      bad++;
      $display("FAIL div_start got div=%b mult=%b exp 1 0", ctrl_DIV, ctrl_MULT);
    end
    cycle();
    DXIR = 32'd0;
    multdiv_ready = 1'b1; multdiv_exception = 1'b1; multdiv_result = 32'hDEAD_BEEF;
    #2;
    total++;
    if (md_wb_grant !== 1'b1 || md_wb_rd !== 5'd30 || md_wb_data !== 32'd5) begin
      bad++;
      $display("FAIL div_exc got g=%b rd=%0d data=%h exp 1 30 5", md_wb_grant, md_wb_rd, md_wb_data);
    end
    cycle();
    quiet();
    DXIR = r_ins(5'd6, 5'd9, 5'd1, 5'd2);
    cycle();
    DXIR = 32'd0;
    multdiv_ready = 1'b1; multdiv_exception = 1'b1; multdiv_result = 32'hDEAD_BEEF;
    #2;
    total++;
    if (md_wb_grant !== 1'b1 || md_wb_rd !== 5'd30 || md_wb_data !== 32'd4) begin
      bad++;
      $display("FAIL mul_exc got g=%b rd=%0d data=%h exp 1 30 4", md_wb_grant, md_wb_rd, md_wb_data);
    end
    cycle();
    quiet();
  endtask

  task automatic test_hazards();
    logic [31:0] fd_vec [8];
    logic        exp_stall [8];
    fd_vec[0] = r_ins(5'd0, 5'd4, 5'd3, 5'd1);  exp_stall[0] = 1'b1;
    fd_vec[1] = r_ins(5'd0, 5'd4, 5'd6, 5'd1);  exp_stall[1] = 1'b0;
    fd_vec[2] = i_ins(5'd5, 5'd3, 5'd6);        exp_stall[2] = 1'b1;
    fd_vec[3] = r_ins(5'd6, 5'd8, 5'd9, 5'd10); exp_stall[3] = 1'b1;
    fd_vec[4] = i_ins(5'd7, 5'd3, 5'd6);        exp_stall[4] = 1'b1;
    fd_vec[5] = i_ins(5'd22, 5'd0, 5'd0);       exp_stall[5] = 1'b1;
    fd_vec[6] = i_ins(5'd4, 5'd3, 5'd0);        exp_stall[6] = 1'b1;
    fd_vec[7] = i_ins(5'd1, 5'd3, 5'd6);        exp_stall[7] = 1'b0;
    cycle();
    DXIR = r_ins(5'd6, 5'd3, 5'd1, 5'd2);
    FDIR = r_ins(5'd0, 5'd4, 5'd1, 5'd3);
    #2;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL haz_start_cycle got stall=%b exp 1", stall);
    end
    for (int i = 0; i < 8; i++) begin
      cycle();
      DXIR = (i == 3) ? r_ins(5'd6, 5'd12, 5'd1, 5'd2) : 32'd0;
      FDIR = fd_vec[i];
      #2;
      total++;
      if (stall !== exp_stall[i] || ctrl_MULT !== 1'b0 || ctrl_DIV !== 1'b0) begin
        bad++;
        $display("FAIL haz_vec%0d got stall=%b mult=%b div=%b exp %b 0 0",
                 i, stall, ctrl_MULT, ctrl_DIV, exp_stall[i]);
      end
    end
    cycle();
    DXIR = 32'd0;
    multdiv_ready = 1'b1; multdiv_result = 32'h0000_0042;
    #2;
    total++;
    if (md_wb_grant !== 1'b1 || md_wb_rd !== 5'd3) begin
      bad++;
      $display("FAIL haz_finish got g=%b rd=%0d exp 1 3", md_wb_grant, md_wb_rd);
    end
    cycle();
    quiet();
  endtask

  task automatic test_r0();
    int grants = 0;
    int stalls = 0;
    cycle();
    DXIR = r_ins(5'd6, 5'd0, 5'd1, 5'd2);
    FDIR = r_ins(5'd0, 5'd4, 5'd0, 5'd0);
    #2;
    total++;
    if (ctrl_MULT !== 1'b1) begin
      bad++;
      $display("FAIL r0_start got mult=%b exp 1", ctrl_MULT);
    end
    for (int i = 0; i < 5; i++) begin
      cycle();
      DXIR = 32'd0;
      multdiv_ready = (i == 3);
      multdiv_result = 32'h0000_0099;
      #2;
      grants += md_wb_grant;
      stalls += stall;
    end
    total++;
    if (grants !== 0 || stalls !== 0) begin
      bad++;
      $display("FAIL r0_silent got grants=%0d stalls=%0d exp 0 0", grants, stalls);
    end
    total++;
    if (md_busy !== 1'b0) begin
      bad++;
      $display("FAIL r0_done got busy=%b exp 0", md_busy);
    end
    quiet();
  endtask

  task automatic test_reset_mid();
    cycle();
    DXIR = r_ins(5'd6, 5'd3, 5'd1, 5'd2);
    cycle();
    DXIR = 32'd0;
    FDIR = r_ins(5'd0, 5'd4, 5'd3, 5'd1);
    reset = 1'b0;
    #2;
    total++;
    if ({ctrl_MULT, ctrl_DIV, stall, md_busy, md_wb_grant} !== 5'd0) begin
      bad++;
      $display("FAIL reset_mid got %b%b%b%b%b exp 00000", ctrl_MULT, ctrl_DIV, stall, md_busy, md_wb_grant);
    end
    cycle();
    reset = 1'b1;
    cycle();
    multdiv_ready = 1'b1; multdiv_result = 32'h7777_7777;
    #2;
    total++;
    if (md_wb_grant !== 1'b0 || md_busy !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_late_ready got g=%b busy=%b stall=%b exp 0 0 0", md_wb_grant, md_busy, stall);
    end
    cycle();
    quiet();
  endtask

  initial begin
    MWIR = MW_FREE;
    test_reset();
    test_mul_grant();
    test_hold();
    test_exception();
    test_hazards();
    test_r0();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multdiv_scoreboard.md
Name: multdiv_scoreboard

Overview:
- Sequences the iterative multiply/divide unit and owns its single outstanding operation.
- Issues start pulses to the unit and tracks the pending destination register.
- Stalls decode on RAW/WAW/structural hazards against the in-flight result.
- Arbitrates the register-file write port between the MW-stage writeback and the late multdiv result, buffering the result when the port is taken.

Parameters:
- MULT_ALUOP, 5'b00110, ALU opcode field (IR[6:2]) selecting mul when IR[31:27]==0
- DIV_ALUOP, 5'b00111, ALU opcode field selecting div
- STATUS_REG, 30, register written on multdiv exception
- MULT_EXC_CODE, 4, value written to STATUS_REG on mul overflow
- DIV_EXC_CODE, 5, value written to STATUS_REG on divide-by-zero

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- FDIR  in  32  instruction in decode
- DXIR  in  32  instruction in execute
- MWIR  in  32  instruction in memory/writeback
- multdiv_ready  in  1  unit result valid (one-cycle pulse)
- multdiv_exception  in  1  qualifies multdiv_ready
- multdiv_result  in  32  unit result
- ctrl_MULT  out  1  start pulse, mul
- ctrl_DIV  out  1  start pulse, div
- stall  out  1  hold PC/FD, insert nop into DX
- md_busy  out  1  operation outstanding (state != IDLE)
- md_wb_grant  out  1  write port used by multdiv this cycle
- md_wb_rd  out  5  write address when granted
- md_wb_data  out  32  write data when granted

Behaviour:
- Decode rules:
  - isMD(IR): IR[31:27]==0 and IR[6:2] is MULT_ALUOP or DIV_ALUOP.
  - rd=IR[26:22], rs=IR[21:17], rt=IR[16:12].
  - FD source registers:
    - ALU op: rs, rt.
    - Ops 7/8: rs, rd.
    - Ops 2/6: rd, rs.
    - Op 4: rd.
    - Op 22: r30.
    - Others: rs.
  - FD writes: ops 0 (non-MD), 5, 8 write rd; op 3 writes r31; op 21 writes r30.
  - mwWrites: MWIR op in {0 non-MD, 3, 5, 8, 21}.
- States: IDLE, BUSY, HOLD.
- Registers: state, pend_rd[4:0], pend_is_div, hold_data[31:0], hold_rd[4:0].
  - Reset: IDLE, all zero.
  - All outputs 0 during reset.
- IDLE:
  - If isMD(DXIR), assert ctrl_MULT or ctrl_DIV combinationally this cycle.
  - Latch pend_rd=DX rd and pend_is_div.
  - Go to BUSY next edge.
  - A start pulse is never issued outside IDLE.
- BUSY, on multdiv_ready:
  - Result selection:
    - data = multdiv_exception ? (pend_is_div ? DIV_EXC_CODE : MULT_EXC_CODE) zero-extended : multdiv_result.
    - rd = multdiv_exception ? STATUS_REG : pend_rd.
  - If mwWrites is 0:
    - Assert md_wb_grant the same cycle with data/rd bypassed combinationally.
    - Go to IDLE.
  - Else capture data into hold_data and rd into hold_rd; go to HOLD.
    - MW always has priority.
- HOLD:
  - Drive hold_rd/hold_data.
  - Assert grant in the first cycle mwWrites is 0, then go to IDLE.
- rd==0 without exception: operation completes normally but md_wb_grant stays 0.
- Hazard check:
  - pend = (state==IDLE and isMD(DXIR)) ? DXIR rd : (HOLD ? hold_rd : pend_rd).
  - active = state!=IDLE or isMD(DXIR).
- stall = active and any of:
  - isMD(FDIR).
  - An FD source equals pend and pend!=0.
  - FD destination equals pend and pend!=0.
  - FD op is 22.
- stall deasserts in the cycle after the grant cycle (state back to IDLE). The grant cycle itself still stalls, with no bypass.
- multdiv_ready while IDLE: ignored.
- Reset mid-operation: immediately IDLE. The result is dropped and the unit is restarted only by a new DX op.

Decomposition:
- Shared package holds:
  - Opcode constants: ALU=0, ADDI=5, SW=7, LW=8, J=1, BNE=2, JAL=3, JR=4, BLT=6, SETX=21, BEX=22.
  - ALU opcodes: MULT_ALUOP, DIV_ALUOP.
  - Exception codes and STATUS_REG.
  - State encoding.
- One sub-module, md_instr_decode, is combinational: it returns isMD, srcA, srcB, dest and writes for one IR. It is instantiated for FD and MW.

Test Plan:
- mul r3,r1,r2 in DX from IDLE -> ctrl_MULT=1 for one cycle. Ready 17 cycles later with MW=nop -> grant=1, rd=3, data=result the same cycle. IDLE next.
- Ready while MWIR=addi r5 -> grant=0, HOLD. Next cycle MW=nop -> grant=1, rd=3, data=held value.
- div with multdiv_exception at ready -> grant with rd=30, data=5. mul exception -> data=4.
- While BUSY (pend_rd=3): FD add r4,r3,r1 -> stall=1. FD add r4,r6,r1 -> stall=0. FD addi r3 -> stall=1 (WAW). FD mul -> stall=1.
- mul r0,... -> unit starts and completes, grant never asserted, stall never raised on r0 sources.
- reset low during BUSY -> all outputs 0, state IDLE. A later ready pulse produces no grant.
